sram_dp_be: RTL
===============

// Module: sram_dp_be
// PURPOSE
//   Simple dual-port synchronous SRAM: one write port and one read port, with byte enables.
//   Read latency (1 or 2) and read-during-write policy are configurable.
//   Built-in clear engine writes CLEAR_VAL to every word after reset or on request.
//   Frame/line storage for the image filter datapath; replaces the single-port cs/write_en SRAM.
// PARAMETERS
//   WIDTH          32         data word width; must be a multiple of BYTE_W
//   BYTE_W         8          bits per byte-enable lane; NB = WIDTH/BYTE_W
//   DEPTH          256*256    number of words; need not be a power of 2
//   RD_LAT         1          read latency in cycles; legal values 1 or 2
//   RDW_MODE       0          same-address read/write in one cycle: 0 = old data, 1 = new data
//   CLEAR_ON_RESET 1          1 = clear engine runs automatically when reset is released
//   CLEAR_VAL      '0         WIDTH-bit value written by the clear engine
// PORTS
//   clk         in   1         clock; all logic on posedge
//   rst         in   1         asynchronous, active-high reset
//   init_start  in   1         pulse: start a clear sweep (sampled only when idle)
//   busy        out  1         clear sweep in progress
//   wr_en       in   1         write request
//   wr_addr     in   AW        write address, AW = $clog2(DEPTH)
//   wr_be       in   NB        byte enables; lane i covers wr_data[i*BYTE_W +: BYTE_W]
//   wr_data     in   WIDTH     write data
//   rd_en       in   1         read request
//   rd_addr     in   AW        read address
//   rd_data     out  WIDTH     read data; holds its value between reads
//   rd_valid    out  1         one-cycle pulse marking rd_data valid
// BEHAVIOUR
//   Reset: rd_data = 0, rd_valid = 0, read pipeline cleared, clear counter = 0.
//     Reset state = CLEAR with busy = 1 if CLEAR_ON_RESET, else IDLE with busy = 0.
//     The memory array has no reset.
//   FSM states IDLE, CLEAR:
//     IDLE -> CLEAR when init_start = 1; busy rises the next cycle.
//     CLEAR writes CLEAR_VAL to counter address, one word per cycle, addresses 0 .. DEPTH-1.
//     After writing DEPTH-1 -> IDLE and busy falls, so a sweep is DEPTH cycles.
//   While busy, or in a cycle where init_start is accepted: wr_en and rd_en are ignored.
//     Reads already in the pipeline still complete and pulse rd_valid.
//   init_start while busy is ignored; the sweep does not restart.
//   rst mid-sweep aborts the sweep. It restarts from address 0 only if CLEAR_ON_RESET = 1.
//   Write: when wr_en, lanes with wr_be[i] = 1 are updated at the clock edge; other lanes keep their value.
//   Read: rd_en sampled at edge N.
//     RD_LAT = 1: rd_data and rd_valid update at edge N+1.
//     RD_LAT = 2: one more output register, so they update at edge N+2.
//     Back-to-back reads give one result per cycle.
//   Read-during-write (rd_en and wr_en, rd_addr == wr_addr, same cycle):
//     RDW_MODE 0: return the pre-write word.
//     RDW_MODE 1: return the merged word (enabled lanes from wr_data, others old).
//   Address >= DEPTH: write is dropped; read returns 0 with rd_valid still pulsed.
//   Elaboration check: $error if WIDTH % BYTE_W != 0 or RD_LAT is not 1 or 2.
// STRUCTURE
//   sram_pkg: typedef enum {IDLE, CLEAR} clr_state_t; localparams RDW_OLD = 0, RDW_NEW = 1.
//   One sub-module, sram_clear_fsm: state register, address counter, busy output,
//     and the write-port override mux. The memory array and read pipeline stay in this module.
// TESTING (WIDTH=32, DEPTH=16, CLEAR_VAL=32'hA5A5_A5A5 unless stated)
//   1. Release rst, CLEAR_ON_RESET=1 -> busy high for exactly 16 cycles;
//      every address then reads A5A5_A5A5.
//   2. Write addr 3 = DEADBEEF with be=4'b0101, then read addr 3 -> A5AD_A5EF.
//      rd_valid pulses 1 cycle after rd_en (RD_LAT=1) or 2 cycles after (RD_LAT=2).
//   3. Same-cycle write addr 5 = 12345678 (be=F) and read addr 5 (prior value 0):
//      RDW_MODE 0 -> 00000000, RDW_MODE 1 -> 12345678; a re-read gives 12345678.
//   4. Streaming reads of addr 0..15 on 16 consecutive cycles ->
//      16 consecutive rd_valid pulses with data in address order.
//   5. Pulse init_start, then wr_en/rd_en during busy -> no memory change and no rd_valid;
//      a second init_start mid-sweep does not extend busy.
//   6. Assert rst at sweep address 7, release -> sweep restarts at 0 and lasts 16 cycles;
//      rd_data and rd_valid are 0 while in reset.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: shared types and constants for the dual-port byte-enable SRAM
package sram_pkg;
  typedef enum logic {IDLE, CLEAR} clr_state_t;
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
endpackage

// File: rtl/sram_clear_fsm.sv
// sram_clear_fsm: clear-sweep state machine and write-port override mux
module sram_clear_fsm
  import sram_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NB = 4,
  parameter int AW = 16,
  parameter int DEPTH = 65536,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_start,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [NB-1:0]    wr_be,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             busy,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [NB-1:0]    mem_be,
  output logic [WIDTH-1:0] mem_data,
  output logic             rd_ok
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  clr_state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic accept, clearing;
  always_comb begin
    clearing = state_q == CLEAR;
    accept = state_q == IDLE && init_start;
    state_d = accept ? CLEAR : (clearing && cnt_q == LAST) ? IDLE : state_q;
    cnt_d = (clearing && cnt_q != LAST) ? cnt_q + 1'b1 : '0;
    mem_we = clearing || (wr_en && !accept);
    mem_addr = clearing ? cnt_q : wr_addr;
    mem_be = clearing ? '1 : wr_be;
    mem_data = clearing ? CLEAR_VAL : wr_data;
    rd_ok = rd_en && !clearing && !accept;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR_ON_RESET != 0 ? CLEAR : IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign busy = state_q == CLEAR;
endmodule

// File: rtl/sram_dp_be.sv
// sram_dp_be: simple dual-port SRAM with byte enables, 1/2-cycle read latency and clear engine
module sram_dp_be
  import sram_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BYTE_W = 8,
  parameter int DEPTH = 256 * 256,
  parameter int RD_LAT = 1,
  parameter int RDW_MODE = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0,
  localparam int NB = WIDTH / BYTE_W,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_start,
  output logic             busy,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [NB-1:0]    wr_be,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);
  if (WIDTH % BYTE_W != 0 || (RD_LAT != 1 && RD_LAT != 2)) begin : g_bad_param
    $error("sram_dp_be: WIDTH must be a multiple of BYTE_W and RD_LAT must be 1 or 2");
  end
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
  logic mem_we, rd_ok, wr_in, rd_in;
  logic [AW-1:0] mem_addr;
  logic [NB-1:0] mem_be;
  logic [WIDTH-1:0] mem_data, rd_word;
  logic [WIDTH-1:0] mem [DEPTH];
  logic rd_v1_q, rd_v1_d, rd_v2_q, rd_v2_d;
  logic [WIDTH-1:0] rd_d1_q, rd_d1_d, rd_d2_q, rd_d2_d;
  sram_clear_fsm #(
    .WIDTH(WIDTH), .NB(NB), .AW(AW), .DEPTH(DEPTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET), .CLEAR_VAL(CLEAR_VAL)
  ) u_clr (
    .clk(clk), .rst(rst), .init_start(init_start),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .busy(busy),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_data(mem_data),
    .rd_ok(rd_ok)
  );
  assign wr_in = {1'b0, mem_addr} < DEPTH_W;
  assign rd_in = {1'b0, rd_addr} < DEPTH_W;
  always_ff @(posedge clk) begin
    if (mem_we && wr_in)
      for (int i = 0; i < NB; i++)
        if (mem_be[i]) mem[mem_addr][i*BYTE_W +: BYTE_W] <= mem_data[i*BYTE_W +: BYTE_W];
  end
  // New-data mode forwards the enabled write lanes over the stored word
  always_comb begin
    rd_word = rd_in ? mem[rd_addr] : '0;
    for (int i = 0; i < NB; i++)
      if (RDW_MODE == RDW_NEW && rd_in && mem_we && mem_addr == rd_addr && mem_be[i])
        rd_word[i*BYTE_W +: BYTE_W] = mem_data[i*BYTE_W +: BYTE_W];
    rd_v1_d = rd_ok;
    rd_d1_d = rd_ok ? rd_word : rd_d1_q;
    rd_v2_d = rd_v1_q;
    rd_d2_d = rd_v1_q ? rd_d1_q : rd_d2_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v1_q <= 1'b0;
      rd_d1_q <= '0;
      rd_v2_q <= 1'b0;
      rd_d2_q <= '0;
    end else begin
      rd_v1_q <= rd_v1_d;
      rd_d1_q <= rd_d1_d;
      rd_v2_q <= rd_v2_d;
      rd_d2_q <= rd_d2_d;
    end
  end
  assign rd_data = RD_LAT == 2 ? rd_d2_q : rd_d1_q;
  assign rd_valid = RD_LAT == 2 ? rd_v2_q : rd_v1_q;
endmodule
